// File: rtl/io_mmio_responder_pkg.sv
// io_mmio_responder_pkg: IO register map, CTRL bit positions, Funct3 load codes
// and the load-extract helper shared by the IO responder.
package io_mmio_responder_pkg;
    localparam logic [3:0] IO_REGION  = 4'b1000;
    localparam logic [7:0] IO_CTRL    = 8'h00;
    localparam logic [7:0] IO_RXDATA  = 8'h04;
    localparam logic [7:0] IO_TXDATA  = 8'h08;
    localparam logic [7:0] IO_CYCLE   = 8'h10;
    localparam logic [7:0] IO_INSTR   = 8'h14;
    localparam logic [7:0] IO_CNT_CLR = 8'h18;

    localparam int CTRL_RX_VALID = 0;
    localparam int CTRL_TX_NFULL = 1;
    localparam int CTRL_TX_OVF   = 2;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;

    typedef enum logic [1:0] {
        LD_BYTE,
        LD_HALF,
        LD_WORD,
        LD_NONE
    } ld_size_e;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        ld_size_e    sz;
        logic        sgn;
        b   = 8'(word >> {off, 3'b000});
        h   = off[1] ? word[31:16] : word[15:0];
        sz  = (f3 == FNC_LB || f3 == FNC_LBU) ? LD_BYTE :
              (f3 == FNC_LH || f3 == FNC_LHU) ? LD_HALF :
              (f3 == FNC_LW) ? LD_WORD : LD_NONE;
        sgn = !f3[2];
        case (sz)
            LD_BYTE: return {{24{sgn & b[7]}}, b};
            LD_HALF: return {{16{sgn & h[15]}}, h};
            LD_WORD: return word;
            default: return 32'h0;
        endcase
    endfunction
endpackage

// File: rtl/io_mmio_responder_tx_fifo.sv
// io_tx_fifo: synchronous FIFO with power-of-two depth; a pop frees a slot for a
// same-cycle push, and the head reads as zero while empty.
module io_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full     = cnt_q == (AW+1)'(DEPTH);
    assign empty    = cnt_q == '0;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = push_data;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/io_mmio_responder.sv
// io_mmio_responder: MMIO responder for UART TX/RX and cycle/instruction counters;
// load data is registered so IO reads share the one-cycle DMEM writeback timing.
module io_mmio_responder
    import io_mmio_responder_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int CW       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [2:0]  Funct3,
    input  logic [3:0]  Io_trans,
    input  logic        Io_recv,
    input  logic [31:0] Wdata,
    input  logic        Inst_retire,
    output logic [31:0] Io_dout,
    output logic [7:0]  UA_tx_data,
    output logic        UA_tx_valid,
    input  logic        UA_tx_ready,
    input  logic [7:0]  UA_rx_data,
    input  logic        UA_rx_valid,
    output logic        UA_rx_ready
);
    logic [31:0]   dout_q, dout_d;
    logic          rx_ready_q, rx_ready_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cycle_q, cycle_d, instr_q, instr_d;
    logic [7:0]    reg_a;
    logic [31:0]   rd_word;
    logic          tx_full, tx_empty, tx_push, tx_pop, cnt_clr, ovf_clr;
    logic          unused_bits;

    // Registers are word-aligned; A[1:0] only picks the lane inside the word.
    assign reg_a       = {A[7:2], 2'b00};
    assign tx_push     = Io_trans[0] && reg_a == IO_TXDATA;
    assign tx_pop      = !tx_empty && UA_tx_ready;
    assign cnt_clr     = |Io_trans && reg_a == IO_CNT_CLR;
    assign ovf_clr     = Io_trans[0] && reg_a == IO_CTRL && Wdata[CTRL_TX_OVF];
    assign UA_tx_valid = !tx_empty;
    assign UA_rx_ready = rx_ready_q;
    assign Io_dout     = dout_q;
    assign unused_bits = ^{A[31:8], Wdata[31:8]};

    io_tx_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (Wdata[7:0]),
        .pop       (tx_pop),
        .pop_data  (UA_tx_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    always_comb begin
        rd_word = '0;
        case (reg_a)
            IO_CTRL: begin
                rd_word[CTRL_RX_VALID] = UA_rx_valid;
                rd_word[CTRL_TX_NFULL] = !tx_full;
                rd_word[CTRL_TX_OVF]   = ovf_q;
            end
            IO_RXDATA: rd_word = {24'h0, UA_rx_data};
            IO_CYCLE:  rd_word = 32'(cycle_q);
            IO_INSTR:  rd_word = 32'(instr_q);
            default:   rd_word = '0;
        endcase
        dout_d     = Io_recv ? load_extract(rd_word, A[1:0], Funct3) : dout_q;
        rx_ready_d = Io_recv && reg_a == IO_RXDATA;
        ovf_d      = (tx_push && tx_full && !tx_pop) || (ovf_q && !ovf_clr);
        cycle_d    = cnt_clr ? '0 : cycle_q + CW'(1);
        instr_d    = cnt_clr ? '0 : instr_q + CW'(Inst_retire);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q     <= '0;
            rx_ready_q <= 1'b0;
            ovf_q      <= 1'b0;
            cycle_q    <= '0;
            instr_q    <= '0;
        end else begin
            dout_q     <= dout_d;
            rx_ready_q <= rx_ready_d;
            ovf_q      <= ovf_d;
            cycle_q    <= cycle_d;
            instr_q    <= instr_d;
        end
    end
endmodule

// File: tb/tb_io_mmio_responder.sv
// tb_io_mmio_responder: directed and random stimulus against a queue-based
// reference model of the IO register map, TX FIFO and counters.
module tb_io_mmio_responder;
    localparam int D  = 4;
    localparam int CW = 10;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [7:0] R_CTRL = 8'h00, R_RX = 8'h04, R_TX = 8'h08, R_CYC = 8'h10, R_INS = 8'h14, R_CLR = 8'h18;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [3:0]  trans;
    logic        recv;
    logic [31:0] wdata;
    logic        retire;
    logic [31:0] dout;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;

    always #5 clk = ~clk;

    io_mmio_responder #(.TX_DEPTH(D), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .A           (a),
        .Funct3      (f3),
        .Io_trans    (trans),
        .Io_recv     (recv),
        .Wdata       (wdata),
        .Inst_retire (retire),
        .Io_dout     (dout),
        .UA_tx_data  (tx_data),
        .UA_tx_valid (tx_valid),
        .UA_tx_ready (tx_ready),
        .UA_rx_data  (rx_data),
        .UA_rx_valid (rx_valid),
        .UA_rx_ready (rx_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned m_q[$];
    bit           m_ovf;
    int unsigned  m_cyc, m_ins;
    logic [31:0]  m_dout;
    bit           m_rxr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input logic [2:0] f);
        int unsigned b, h;
        b = (w >> (8 * off)) % 256;
        h = (w >> (16 * (off / 2))) % 65536;
        case (f)
            LB:      return b >= 128 ? 32'(b) - 32'd256 : 32'(b);
            LBU:     return 32'(b);
            LH:      return h >= 32768 ? 32'(h) - 32'd65536 : 32'(h);
            LHU:     return 32'(h);
            default: return w;
        endcase
    endfunction

    // Model the edge from the current inputs, then compare the DUT just after it.
    task automatic tick();
        int unsigned word;
        int          ra;
        ra = int'(a[7:0]) / 4 * 4;
        if (!rst) begin
            m_q.delete();
            m_ovf  = 0;
            m_cyc  = 0;
            m_ins  = 0;
            m_dout = 0;
            m_rxr  = 0;
        end else begin
            if (recv) begin
                word = 0;
                if (ra == 0) word = (m_ovf ? 4 : 0) + (m_q.size() < D ? 2 : 0) + (rx_valid ? 1 : 0);
                if (ra == 4) word = rx_data;
                if (ra == 'h10) word = m_cyc;
                if (ra == 'h14) word = m_ins;
                m_dout = ref_load(word, int'(a[1:0]), f3);
            end
            m_rxr = recv && ra == 4;
            if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
            if (trans[0] && ra == 8) begin
                if (m_q.size() < D) m_q.push_back(wdata[7:0]);
                else m_ovf = 1;
            end
            if (trans[0] && ra == 0 && wdata[2]) m_ovf = 0;
            if (trans != 0 && ra == 'h18) begin
                m_cyc = 0;
                m_ins = 0;
            end else begin
                m_cyc = (m_cyc + 1) % (1 << CW);
                m_ins = (m_ins + retire) % (1 << CW);
            end
        end
        @(posedge clk);
        #1;
        check("dout", dout, m_dout);
        check("rx_ready", rx_ready, m_rxr);
        check("tx_valid", tx_valid, m_q.size() > 0);
        if (m_q.size() > 0) check("tx_data", tx_data, m_q[0]);
    endtask

    task automatic set_idle();
        a      = 32'h8000_0000;
        f3     = LW;
        trans  = 4'b0;
        recv   = 1'b0;
        wdata  = 32'h0;
        retire = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, input logic [2:0] f);
        set_idle();
        a[7:0] = off;
        f3     = f;
        recv   = 1'b1;
        tick();
        recv   = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [3:0] t, input logic [31:0] d);
        set_idle();
        a[7:0] = off;
        trans  = t;
        wdata  = d;
        tick();
        trans  = 4'b0;
    endtask

    int          regs[7] = '{0, 4, 8, 'h10, 'h14, 'h18, 'h1C};
    logic [2:0]  fns[5]  = '{LB, LH, LW, LBU, LHU};

    initial begin
        rst = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
        set_idle();
        tick();
        tick();
        check("rst_dout", dout, 32'h0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_tx_data", tx_data, 8'h0);
        rst = 1'b1;
        rd(R_CTRL, LW);
        check("ctrl_after_rst", dout, 32'h2);
        rd(R_CYC, LW);
        check("cycle_after_rst", dout, 32'h1);

        for (int i = 0; i < 4; i++) wr(R_TX, 4'b0001, 32'h41 + i);
        rd(R_CTRL, LW);
        check("ctrl_full", dout, 32'h0);
        wr(R_TX, 4'b0001, 32'h45);
        rd(R_CTRL, LW);
        check("ctrl_overflow", dout, 32'h4);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", tx_data, 8'h41 + 8'(i));
            set_idle();
            tick();
        end
        check("drained", tx_valid, 1'b0);
        tx_ready = 1'b0;
        wr(R_CTRL, 4'b0001, 32'h4);
        rd(R_CTRL, LW);
        check("ovf_cleared", dout, 32'h2);

        rx_valid = 1'b1; rx_data = 8'hF0;
        rd(R_RX, LB);
        check("rx_lb", dout, 32'hFFFF_FFF0);
        check("rx_pop_pulse", rx_ready, 1'b1);
        set_idle();
        tick();
        check("rx_pop_once", rx_ready, 1'b0);
        rd(R_RX, LBU);
        check("rx_lbu", dout, 32'h0000_00F0);
        rx_valid = 1'b0;

        for (int i = 0; i < 4; i++) wr(R_TX, 4'b0001, 32'h51 + i);
        tx_ready = 1'b1;
        wr(R_TX, 4'b0001, 32'h55);
        tx_ready = 1'b0;
        rd(R_CTRL, LW);
        check("full_push_pop", dout, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_pp_order", tx_data, 8'h52 + 8'(i));
            set_idle();
            tick();
        end
        tx_ready = 1'b0;

        while (m_cyc != (1 << CW) - 1) begin
            set_idle();
            tick();
        end
        rd(R_CYC, LW);
        check("cycle_max", dout, 32'h3FF);
        rd(R_CYC, LW);
        check("cycle_wrap", dout, 32'h0);
        for (int i = 0; i < 3; i++) begin
            set_idle();
            retire = 1'b1;
            tick();
        end
        set_idle();
        a[7:0] = R_CLR;
        trans  = 4'b1000;
        retire = 1'b1;
        tick();
        rd(R_INS, LW);
        check("instr_clr_wins", dout, 32'h0);
        rd(R_CYC, LW);
        check("cycle_after_clr", dout, 32'h1);

        for (int i = 0; i < 3; i++) wr(R_TX, 4'b0001, 32'h61 + i);
        rst = 1'b0;
        tx_ready = 1'b1;
        set_idle();
        tick();
        check("rst_mid_drain", tx_valid, 1'b0);
        rst = 1'b1;
        wr(R_TX, 4'b0001, 32'h70);
        check("new_byte_only", tx_data, 8'h70);
        set_idle();
        tick();
        check("only_one_byte", tx_valid, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            set_idle();
            rst      = $urandom_range(0, 199) != 0;
            tx_ready = $urandom_range(0, 2) == 0;
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            retire   = 1'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    recv   = 1'b1;
                    a[7:0] = 8'(regs[$urandom_range(0, 6)] + $urandom_range(0, 3));
                    f3     = fns[$urandom_range(0, 4)];
                end
                3, 4, 5: begin
                    a[7:0] = R_TX;
                    trans  = 4'b0001;
                    wdata  = $urandom;
                end
                6: begin
                    a[7:0] = R_CTRL;
                    trans  = 4'b0001;
                    wdata  = $urandom;
                end
                7: if ($urandom_range(0, 9) == 0) begin
                    a[7:0] = R_CLR;
                    trans  = 4'($urandom_range(1, 15));
                end
                8: begin
                    a[7:0] = $urandom_range(0, 1) ? 8'h0C : 8'h20;
                    trans  = 4'($urandom_range(1, 15));
                    wdata  = $urandom;
                end
                default: ;
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
